digi_frame_packer: RTL and testbench

- Downstream of the multi-channel digitizer block. Consumes its muxed 16-bit readout stream while the Zynq read-enable is high.
- Tags each sample with its channel ID and buffers samples in a FIFO.
- Emits one framed packet per readout (2 header words, data words, 1 checksum trailer) over a valid/ready stream to the SPI transmitter.
- Decouples digitizer readout timing from SPI backpressure.

---
 rtl/digi_frame_packer.sv | 180 ++++++++++++++++++
 tb/tb_digi_frame_packer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digi_frame_packer.sv
// Packs one digitizer readout into a framed packet: two header words, channel-tagged
// samples buffered in a first-word-fall-through FIFO, and an XOR checksum trailer.
module digi_frame_packer #(
    parameter int WIDTH = 16,
    parameter int CHAN  = 8,
    parameter int AW    = 10
) (
    input  logic             CK50,
    input  logic             RST_n,
    input  logic             RD_EN_in,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    input  logic [11:0]      SAMPLE_NUM,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST,
    output logic             OVERFLOW,
    output logic [7:0]       DROP_CNT,
    output logic             BUSY
);
    localparam int DEPTH = 1 << AW;
    localparam int PW    = AW + 1;
    localparam int CW    = $clog2(CHAN + 1);

    typedef enum logic [1:0] {IN_IDLE, IN_RUN, IN_DONE} in_state_t;
    typedef enum logic [2:0] {OUT_IDLE, HDR0, HDR1, DATA, TRL} out_state_t;

    in_state_t        in_state, in_next;
    out_state_t       out_state, out_next;
    logic             rd_q, frame_open;
    logic [11:0]      sn, wc, evt_num;
    logic [CW-1:0]    ch;
    logic [15:0]      nw, pop_cnt;
    logic [7:0]       drop_cnt;
    logic             overflow;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head, chk, wr_word;
    logic             head_vld;
    logic [PW-1:0]    wr_ptr, rd_ptr, total;
    logic             rise, accept, drop, in_done, wr_req, wr_en, full, pop, load, hs;
    logic [3:0]       cid;
    logic             unused_din;

    assign unused_din = ^DIN[3:0];
    assign rise       = RD_EN_in & ~rd_q;
    assign accept     = rise && (in_state == IN_IDLE) && (out_state == OUT_IDLE);
    assign drop       = rise && !accept;
    assign in_done    = (in_state == IN_DONE);
    assign wr_req     = (in_state == IN_RUN) && RD_EN_in && DIN_VALID;

    // Occupancy counts the output register too, so capacity is exactly DEPTH words.
    assign total   = (wr_ptr - rd_ptr) + PW'(head_vld);
    assign full    = (total == PW'(DEPTH));
    assign pop     = (out_state == DATA) && head_vld && OUT_READY;
    assign wr_en   = wr_req && (!full || pop);
    assign load    = (wr_ptr != rd_ptr) && (!head_vld || pop);
    assign hs      = OUT_VALID && OUT_READY;
    assign wr_word = {DIN[WIDTH-1:4], cid};

    assign OVERFLOW = overflow;
    assign DROP_CNT = drop_cnt;
    assign BUSY     = (in_state != IN_IDLE) || (out_state != OUT_IDLE);

    always_comb begin
        cid = 4'hF;
        if (sn == 12'd0)
            cid = 4'(CHAN - 1);
        else if (int'(ch) < CHAN)
            cid = 4'(CHAN - 1 - int'(ch));
    end

    always_comb begin
        in_next = in_state;
        case (in_state)
            IN_IDLE: if (accept) in_next = IN_RUN;
            IN_RUN:  if (!RD_EN_in) in_next = IN_DONE;
            IN_DONE: if (out_state == OUT_IDLE) in_next = IN_IDLE;
            default: in_next = IN_IDLE;
        endcase
    end

    always_comb begin
        out_next  = out_state;
        OUT_DATA  = '0;
        OUT_VALID = 1'b0;
        OUT_LAST  = 1'b0;
        case (out_state)
            OUT_IDLE: if (frame_open) out_next = HDR0;
            HDR0: begin
                OUT_DATA  = WIDTH'({4'hA, evt_num});
                OUT_VALID = 1'b1;
                if (OUT_READY) out_next = HDR1;
            end
            HDR1: begin
                OUT_DATA  = WIDTH'({4'h5, sn});
                OUT_VALID = 1'b1;
                if (OUT_READY) out_next = DATA;
            end
            DATA: begin
                OUT_DATA  = head;
                OUT_VALID = head_vld;
                if (in_done && (pop_cnt == nw)) out_next = TRL;
            end
            TRL: begin
                OUT_DATA  = chk;
                OUT_VALID = 1'b1;
                OUT_LAST  = 1'b1;
                if (OUT_READY) out_next = OUT_IDLE;
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge CK50) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge CK50) begin
        if (!RST_n) begin
            in_state   <= IN_IDLE;
            out_state  <= OUT_IDLE;
            rd_q       <= 1'b0;
            frame_open <= 1'b0;
            sn         <= '0;
            wc         <= '0;
            ch         <= '0;
            evt_num    <= '0;
            nw         <= '0;
            pop_cnt    <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            head       <= '0;
            head_vld   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            chk        <= '0;
        end else begin
            in_state   <= in_next;
            out_state  <= out_next;
            rd_q       <= RD_EN_in;
            frame_open <= accept;
            if (accept) begin
                sn      <= SAMPLE_NUM;
                wc      <= '0;
                ch      <= '0;
                nw      <= '0;
                pop_cnt <= '0;
            end
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
            // Channel tagging follows the input stream position, even for discarded words.
            if (wr_req && (sn != 12'd0)) begin
                if (wc == sn - 12'd1) begin
                    wc <= '0;
                    if (int'(ch) < CHAN) ch <= ch + CW'(1);
                end else begin
                    wc <= wc + 12'd1;
                end
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                nw     <= nw + 16'd1;
            end
            if (wr_req && !wr_en) overflow <= 1'b1;
            if (load) begin
                head     <= mem[rd_ptr[AW-1:0]];
                head_vld <= 1'b1;
                rd_ptr   <= rd_ptr + PW'(1);
            end else if (pop) begin
                head_vld <= 1'b0;
            end
            if (pop) pop_cnt <= pop_cnt + 16'd1;
            if (out_state == OUT_IDLE)
                chk <= '0;
            else if (hs && (out_state != TRL))
                chk <= chk ^ OUT_DATA;
            if ((out_state == TRL) && OUT_READY) evt_num <= evt_num + 12'd1;
        end
    end
endmodule

// File: tb/tb_digi_frame_packer.sv
// Randomized bench for digi_frame_packer: packets are predicted from the framing rules
// (headers, positional channel tags, XOR trailer) and compared word by word.
module tb_digi_frame_packer;
    localparam int WIDTH = 16;
    localparam int CHAN  = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic              CK50 = 1'b0;
    logic              RST_n;
    logic              RD_EN_in;
    logic [WIDTH-1:0]  DIN;
    logic              DIN_VALID;
    logic [11:0]       SAMPLE_NUM;
    logic [WIDTH-1:0]  OUT_DATA;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b0;
    logic              OUT_LAST;
    logic              OVERFLOW;
    logic [7:0]        DROP_CNT;
    logic              BUSY;

    int checks = 0;
    int errors = 0;
    int evt_model = 0;
    int ready_mode = 0;
    logic ready_const = 1'b0;

    logic [15:0] wr_q[$];
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          lasts_seen = 0;
    int          stable_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    digi_frame_packer #(.WIDTH(WIDTH), .CHAN(CHAN), .AW(AW)) dut (
        .CK50(CK50), .RST_n(RST_n), .RD_EN_in(RD_EN_in), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .SAMPLE_NUM(SAMPLE_NUM), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .OVERFLOW(OVERFLOW),
        .DROP_CNT(DROP_CNT), .BUSY(BUSY)
    );

    always #10 CK50 = ~CK50;

    // Consumer: constant, alternating or random ready, updated just after each edge.
    always @(posedge CK50) begin
        #2;
        case (ready_mode)
            0:       OUT_READY = ready_const;
            1:       OUT_READY = ~OUT_READY;
            default: OUT_READY = 1'($urandom_range(0, 1));
        endcase
    end

    // Collects accepted words as {last, data} and tracks stability while stalled.
    always @(negedge CK50) begin
        if (!RST_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (OUT_VALID !== 1'b1 || OUT_DATA !== prev_data || OUT_LAST !== prev_last))
                stable_viol++;
            if (OUT_VALID && OUT_READY) begin
                got_q.push_back({OUT_LAST, OUT_DATA});
                if (OUT_LAST) lasts_seen++;
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
            prev_last  = OUT_LAST;
        end
    end

    // Rise cycle, then nwords DIN_VALID cycles (optional random gaps), then the fall cycle.
    task automatic drive_frame(input logic [11:0] sn, input int nwords, input bit gaps,
                               input bit fixed, input logic [15:0] fixed_val);
        wr_q.delete();
        @(posedge CK50); #2;
        SAMPLE_NUM = sn; RD_EN_in = 1'b1; DIN_VALID = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge CK50); #2;
                DIN_VALID = 1'b0; DIN = 16'($urandom);
            end
            @(posedge CK50); #2;
            DIN = fixed ? fixed_val : 16'($urandom);
            DIN_VALID = 1'b1;
            wr_q.push_back(DIN);
        end
        @(posedge CK50); #2;
        RD_EN_in = 1'b0; DIN_VALID = 1'($urandom_range(0, 1)); DIN = 16'($urandom);
        SAMPLE_NUM = 12'($urandom);
        @(posedge CK50); #2;
        DIN_VALID = 1'b0;
    endtask

    task automatic wait_packet(input int base_lasts, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CK50); #1;
            if (lasts_seen > base_lasts) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge CK50);
        #1;
    endtask

    // Expected packet from the framing rules; limit caps how many written words survive.
    task automatic model_packet(input logic [11:0] sn, input int limit);
        logic [15:0] h0, h1, w, x, raw;
        logic [3:0]  cid;
        int          n, chn;
        exp_q.delete();
        h0 = {4'hA, 12'(evt_model)};
        h1 = {4'h5, sn};
        x  = h0 ^ h1;
        exp_q.push_back({1'b0, h0});
        exp_q.push_back({1'b0, h1});
        n = (wr_q.size() < limit) ? wr_q.size() : limit;
        for (int k = 0; k < n; k++) begin
            if (sn == 12'd0) begin
                cid = 4'(CHAN - 1);
            end else begin
                chn = k / int'(sn);
                cid = (chn < CHAN) ? 4'(CHAN - 1 - chn) : 4'hF;
            end
            raw = wr_q[k];
            w   = {raw[15:4], cid};
            x   = x ^ w;
            exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, x});
    endtask

    task automatic test_reset();
        RST_n = 1'b0; RD_EN_in = 1'b0; DIN = '0; DIN_VALID = 1'b0; SAMPLE_NUM = '0;
        repeat (3) @(posedge CK50);
        @(negedge CK50);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", OUT_VALID); end
        checks++; if (OUT_DATA !== 16'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", OUT_DATA); end
        checks++; if (OUT_LAST !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", OUT_LAST); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", OVERFLOW); end
        checks++; if (DROP_CNT !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", DROP_CNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
        @(posedge CK50); #2;
        RST_n = 1'b1;
        repeat (2) @(posedge CK50);
        evt_model = 0;
    endtask

    task automatic test_basic();
        int base, lb; bit ok; logic [16:0] g;
        ready_mode = 0; ready_const = 1'b1;
        base = got_q.size(); lb = lasts_seen;
        drive_frame(12'd4, 32, 1'b0, 1'b1, 16'h1230);
        wait_packet(lb, ok);
        model_packet(12'd4, 100000);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: no trailer, got %0d words", got_q.size() - base); end
        checks++; if (got_q.size() - base != exp_q.size()) begin errors++; $display("[TB] FAIL basic_length: got %0d words expected %0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_word%0d: got %h expected %h (bit16=last)", i, g, exp_q[i]); end
        end
        g = (base < got_q.size()) ? got_q[base] : 17'bx;
        checks++; if (g !== 17'h0A000) begin errors++; $display("[TB] FAIL basic_hdr0: got %h expected 0a000", g); end
        g = (base + 2 < got_q.size()) ? got_q[base + 2] : 17'bx;
        checks++; if (g !== 17'h01237) begin errors++; $display("[TB] FAIL basic_first_data: got %h expected 01237", g); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", BUSY); end
        evt_model++;
    endtask

    task automatic test_random_frames();
        int base, lb, nwords; bit ok; logic [16:0] g; logic [11:0] sn;
        ready_mode = 0; ready_const = 1'b1;
        for (int f = 0; f < 5; f++) begin
            sn = 12'($urandom_range(0, 3));
            nwords = (sn == 0) ? $urandom_range(0, 5) : $urandom_range(1, int'(sn) * CHAN + 3);
            base = got_q.size(); lb = lasts_seen;
            drive_frame(sn, nwords, 1'b1, 1'b0, 16'h0);
            wait_packet(lb, ok);
            model_packet(sn, 100000);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_timeout: no trailer", f); end
            checks++; if (got_q.size() - base != exp_q.size()) begin errors++; $display("[TB] FAIL rand%0d_length: got %0d words expected %0d", f, got_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
                checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL rand%0d_word%0d: got %h expected %h (bit16=last)", f, i, g, exp_q[i]); end
            end
            evt_model++;
        end
    endtask

    task automatic test_backpressure();
        int base, lb, sv, nwords; bit ok; logic [16:0] g; logic [11:0] sn;
        for (int r = 0; r < 2; r++) begin
            ready_mode = (r == 0) ? 1 : 2;
            sn = (r == 0) ? 12'd2 : 12'($urandom_range(1, 2));
            nwords = (r == 0) ? 16 : $urandom_range(8, 16);
            base = got_q.size(); lb = lasts_seen; sv = stable_viol;
            drive_frame(sn, nwords, 1'b0, 1'b0, 16'h0);
            wait_packet(lb, ok);
            model_packet(sn, 100000);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL bp%0d_timeout: no trailer", r); end
            checks++; if (got_q.size() - base != exp_q.size()) begin errors++; $display("[TB] FAIL bp%0d_length: got %0d words expected %0d", r, got_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
                checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL bp%0d_word%0d: got %h expected %h (bit16=last)", r, i, g, exp_q[i]); end
            end
            checks++; if (stable_viol != sv) begin errors++; $display("[TB] FAIL bp%0d_stable: got %0d changes while stalled, expected 0", r, stable_viol - sv); end
            evt_model++;
        end
        ready_mode = 0; ready_const = 1'b1;
        repeat (2) @(posedge CK50);
    endtask

    task automatic test_empty_frame();
        int base, lb; bit ok; logic [16:0] g; logic [11:0] sn;
        ready_mode = 0; ready_const = 1'b1;
        sn = 12'($urandom_range(1, 4095));
        base = got_q.size(); lb = lasts_seen;
        drive_frame(sn, 0, 1'b0, 1'b0, 16'h0);
        wait_packet(lb, ok);
        model_packet(sn, 100000);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL empty_timeout: no trailer"); end
        checks++; if (got_q.size() - base != 3) begin errors++; $display("[TB] FAIL empty_length: got %0d words expected 3", got_q.size() - base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL empty_word%0d: got %h expected %h (bit16=last)", i, g, exp_q[i]); end
        end
        evt_model++;
    endtask

    task automatic test_drop();
        int base, lb; bit ok; logic [16:0] g; logic [15:0] saved[$];
        ready_mode = 0; ready_const = 1'b0;
        repeat (2) @(posedge CK50);
        base = got_q.size(); lb = lasts_seen;
        drive_frame(12'd2, 6, 1'b0, 1'b0, 16'h0);
        saved = wr_q;
        repeat (2) @(posedge CK50);
        drive_frame(12'd3, 5, 1'b0, 1'b0, 16'h0);
        repeat (2) @(negedge CK50);
        checks++; if (DROP_CNT !== 8'd1) begin errors++; $display("[TB] FAIL drop_count: got %0d expected 1", DROP_CNT); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy: got %b expected 1", BUSY); end
        checks++; if (got_q.size() != base) begin errors++; $display("[TB] FAIL drop_stalled: got %0d words while stalled, expected 0", got_q.size() - base); end
        wr_q = saved;
        ready_const = 1'b1;
        wait_packet(lb, ok);
        model_packet(12'd2, 100000);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_timeout: no trailer"); end
        checks++; if (got_q.size() - base != exp_q.size()) begin errors++; $display("[TB] FAIL drop_length: got %0d words expected %0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL drop_word%0d: got %h expected %h (bit16=last)", i, g, exp_q[i]); end
        end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy_end: got %b expected 0", BUSY); end
        evt_model++;
    endtask

    task automatic test_overflow();
        int base, lb; bit ok; logic [16:0] g;
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before: got %b expected 0", OVERFLOW); end
        ready_mode = 0; ready_const = 1'b0;
        repeat (2) @(posedge CK50);
        base = got_q.size(); lb = lasts_seen;
        drive_frame(12'd5, 40, 1'b0, 1'b0, 16'h0);
        repeat (2) @(negedge CK50);
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", OVERFLOW); end
        ready_const = 1'b1;
        wait_packet(lb, ok);
        model_packet(12'd5, DEPTH);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_timeout: no trailer"); end
        checks++; if (got_q.size() - base != DEPTH + 3) begin errors++; $display("[TB] FAIL ovf_length: got %0d words expected %0d", got_q.size() - base, DEPTH + 3); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL ovf_word%0d: got %h expected %h (bit16=last)", i, g, exp_q[i]); end
        end
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", OVERFLOW); end
        evt_model++;
    endtask

    task automatic test_reset_mid_frame();
        int base, lb; bit ok; logic [16:0] g;
        ready_mode = 0; ready_const = 1'b1;
        @(posedge CK50); #2;
        SAMPLE_NUM = 12'd4; RD_EN_in = 1'b1; DIN_VALID = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CK50); #2;
            DIN = 16'($urandom); DIN_VALID = 1'b1;
        end
        @(negedge CK50);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", BUSY); end
        @(posedge CK50); #2;
        RST_n = 1'b0; RD_EN_in = 1'b0; DIN_VALID = 1'b0;
        @(posedge CK50);
        @(negedge CK50);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b expected 0", OUT_VALID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", BUSY); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_overflow: got %b expected 0", OVERFLOW); end
        checks++; if (DROP_CNT !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_drop: got %0d expected 0", DROP_CNT); end
        @(posedge CK50); #2;
        RST_n = 1'b1;
        evt_model = 0;
        repeat (2) @(posedge CK50);
        base = got_q.size(); lb = lasts_seen;
        drive_frame(12'd3, 10, 1'b1, 1'b0, 16'h0);
        wait_packet(lb, ok);
        model_packet(12'd3, 100000);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_timeout: no trailer"); end
        checks++; if (got_q.size() - base != exp_q.size()) begin errors++; $display("[TB] FAIL rstmid_length: got %0d words expected %0d", got_q.size() - base, exp_q.size()); end
        g = (base < got_q.size()) ? got_q[base] : 17'bx;
        checks++; if (g !== 17'h0A000) begin errors++; $display("[TB] FAIL rstmid_hdr0: got %h expected 0a000", g); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (base + i < got_q.size()) ? got_q[base + i] : 17'bx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("[TB] FAIL rstmid_word%0d: got %h expected %h (bit16=last)", i, g, exp_q[i]); end
        end
        evt_model++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_frames();
        test_backpressure();
        test_empty_frame();
        test_drop();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
